yutorina_rst_req_gen: RTL and testbench



---
 rtl/yutorina_rst_req_gen_pkg.sv | 31 +++
 rtl/yutorina_wdt_cnt.sv | 93 +++++++++
 rtl/yutorina_rst_req_gen.sv | 116 +++++++++++
 tb/tb_yutorina_rst_req_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/yutorina_rst_req_gen_pkg.sv
// Shared encodings for the reset-request generator: cause codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package yutorina_rst_req_gen_pkg;

  // Sticky reset cause codes reported on rst_cause
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  // Request FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_HOLD     = 2'b01,
    ST_WAIT_ACK = 2'b10
  } state_t;

  // Encode the events seen in one cycle into a cause code
  function automatic logic [1:0] cause_enc(input logic sw, input logic wdt);
    logic [1:0] c;
    case ({wdt, sw})
      2'b01:   c = CAUSE_SW;
      2'b10:   c = CAUSE_WDT;
      2'b11:   c = CAUSE_BOTH;
      default: c = CAUSE_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/yutorina_wdt_cnt.sv
// Watchdog down-counter with one-shot timeout detection (and pre-warning with YUTORINA_WDT_WARN_EN).
// Latency: count updates every cycle; timeout is combinational from the registered count.
// Backpressure: none; timeout is a level that the caller samples or ignores.
module yutorina_wdt_cnt #(
  parameter int WDT_W = 16
`ifdef YUTORINA_WDT_WARN_EN
  , parameter int WARN_CYC = 64
`endif
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             i_en,
  input  logic [WDT_W-1:0] i_load,
  input  logic             i_kick,
  input  logic             i_reload,
  output logic [WDT_W-1:0] o_cnt,
  output logic             o_timeout
`ifdef YUTORINA_WDT_WARN_EN
  , output logic           o_warn
`endif
);

  localparam logic [WDT_W-1:0] ONE = WDT_W'(1);

  logic             r_en_d;
  logic             r_fired;
  logic [WDT_W-1:0] r_cnt;
  logic [WDT_W-1:0] w_cnt_nxt;
  logic             w_en_rise;
  logic             w_zero;
  logic             w_timeout;

  assign w_en_rise = i_en & ~r_en_d;
  assign w_zero    = (r_cnt == '0);
  // The edge cycle itself only loads; the timeout can fire from the cycle after.
  assign w_timeout = i_en & w_zero & ~i_kick & ~r_fired & ~w_en_rise;

  // Next count: FSM reload / enable edge, then kick, then decrement; frozen while disabled
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_reload || w_en_rise) begin
      w_cnt_nxt = i_load;
    end else if (i_en) begin
      if (i_kick) begin
        w_cnt_nxt = i_load;
      end else if (!w_zero) begin
        w_cnt_nxt = r_cnt - ONE;
      end
    end
  end

  // Count, enable history and the one-shot flag that keeps a timeout from repeating at zero
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_cnt   <= '0;
      r_en_d  <= 1'b0;
      r_fired <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_en_d <= i_en;
      if (i_reload || w_en_rise || (i_en && i_kick)) begin
        r_fired <= 1'b0;
      end else if (w_timeout) begin
        r_fired <= 1'b1;
      end
    end
  end

  assign o_cnt     = r_cnt;
  assign o_timeout = w_timeout;

`ifdef YUTORINA_WDT_WARN_EN
  localparam logic [WDT_W-1:0] WARN_V = WDT_W'(WARN_CYC);

  logic r_warn;
  logic w_warn_nxt;

  // Only a real countdown through the threshold warns; loads at or below it never do.
  assign w_warn_nxt = i_en & (w_cnt_nxt == WARN_V) & (r_cnt != WARN_V) & (i_load > WARN_V);

  // One-cycle warning pulse aligned with the count showing the threshold
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= w_warn_nxt;
    end
  end

  assign o_warn = r_warn;
`endif

endmodule

// File: rtl/yutorina_rst_req_gen.sv
// Reset-request generator: merges software and watchdog requests into a stretched rst_req and a sticky cause.
// Latency: rst_req rises 1 cycle after the request; held HOLD_CYC cycles minimum, then until rst_ack.
// Backpressure: requests outside IDLE are dropped, never queued. Optional: YUTORINA_WDT_WARN_EN adds wdt_warn.
module yutorina_rst_req_gen #(
  parameter int WDT_W    = 16,
  parameter int HOLD_CYC = 8
`ifdef YUTORINA_WDT_WARN_EN
  , parameter int WARN_CYC = 64
`endif
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             wdt_en,
  input  logic [WDT_W-1:0] wdt_load,
  input  logic             wdt_kick,
  input  logic             sw_rst_req,
  input  logic             rst_ack,
  output logic             rst_req,
  output logic [1:0]       rst_cause,
  output logic [WDT_W-1:0] wdt_cnt,
  output logic             busy
`ifdef YUTORINA_WDT_WARN_EN
  , output logic           wdt_warn
`endif
);

  import yutorina_rst_req_gen_pkg::*;

  localparam int             HOLD_W    = $clog2(HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [1:0]        r_cause;
  logic [1:0]        w_cause_nxt;
  logic              r_rst_req;
  logic              w_reload;
  logic              w_timeout;

  yutorina_wdt_cnt #(
    .WDT_W    (WDT_W)
`ifdef YUTORINA_WDT_WARN_EN
    , .WARN_CYC (WARN_CYC)
`endif
  ) u_wdt_cnt (
    .clk       (clk),
    .rst_      (rst_),
    .i_en      (wdt_en),
    .i_load    (wdt_load),
    .i_kick    (wdt_kick),
    .i_reload  (w_reload),
    .o_cnt     (wdt_cnt),
    .o_timeout (w_timeout)
`ifdef YUTORINA_WDT_WARN_EN
    , .o_warn  (wdt_warn)
`endif
  );

  // Next-state, hold countdown and cause capture; the watchdog reloads on leaving WAIT_ACK
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_cause_nxt = r_cause;
    w_reload    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_timeout || sw_rst_req) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = HOLD_INIT;
          w_cause_nxt = cause_enc(sw_rst_req, w_timeout);
        end
      end
      ST_HOLD: begin
        // Counter reaching 0 coincides with the move to WAIT_ACK; rst_ack is not looked at here.
        if (r_hold_cnt <= HOLD_ONE) begin
          w_state_nxt = ST_WAIT_ACK;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt  = r_hold_cnt - HOLD_ONE;
        end
      end
      ST_WAIT_ACK: begin
        if (rst_ack) begin
          w_state_nxt = ST_IDLE;
          w_reload    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State registers; rst_req is registered from the next state so it cannot glitch between states
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_cause    <= CAUSE_NONE;
      r_rst_req  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_cause    <= w_cause_nxt;
      r_rst_req  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign rst_req   = r_rst_req;
  assign rst_cause = r_cause;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_yutorina_rst_req_gen.sv
// Bench for yutorina_rst_req_gen: expected requests queued by stimulus, checked by a negedge monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_yutorina_rst_req_gen;

  logic        clk;
  logic        rst_;
  logic        wdt_en;
  logic [15:0] wdt_load;
  logic        wdt_kick;
  logic        sw_rst_req;
  logic        rst_ack;
  logic        rst_req;
  logic [1:0]  rst_cause;
  logic [15:0] wdt_cnt;
  logic        busy;
`ifdef YUTORINA_WDT_WARN_EN
  logic        wdt_warn;
`endif

  yutorina_rst_req_gen dut (
    .clk        (clk),
    .rst_       (rst_),
    .wdt_en     (wdt_en),
    .wdt_load   (wdt_load),
    .wdt_kick   (wdt_kick),
    .sw_rst_req (sw_rst_req),
    .rst_ack    (rst_ack),
    .rst_req    (rst_req),
    .rst_cause  (rst_cause),
    .wdt_cnt    (wdt_cnt),
    .busy       (busy)
`ifdef YUTORINA_WDT_WARN_EN
    , .wdt_warn (wdt_warn)
`endif
  );

  typedef struct {
    int rise;
    int cause;
    int len;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_sw();
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
  endtask

  // Monitor: each completed rst_req pulse is matched against the next queued expectation
  logic mon_prev  = 1'b0;
  int   mon_start = 0;
  int   mon_cause = 0;
  always @(negedge clk) begin
    if (rst_req && !mon_prev) begin
      mon_start = cyc;
      mon_cause = int'(rst_cause);
    end
    if (!rst_req && mon_prev) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: pulse from cycle %0d to %0d, none expected", mon_start, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("req_rise_cycle", mon_start, e.rise);
        chk("req_cause", mon_cause, e.cause);
        chk("req_high_len", cyc - mon_start, e.len);
      end
    end
    mon_prev = rst_req;
  end

  initial begin
    int min_cnt;
    int saw_req;
    rst_       = 1'b0;
    wdt_en     = 1'b0;
    wdt_load   = 16'd0;
    wdt_kick   = 1'b0;
    sw_rst_req = 1'b0;
    rst_ack    = 1'b1;

    // Reset state
    wait_cyc(1);
    chk("rst_rst_req", int'(rst_req), 0);
    chk("rst_cause", int'(rst_cause), 0);
    chk("rst_wdt_cnt", int'(wdt_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    wait_cyc(3);
    rst_ = 1'b1;

    // Software request at cycle 10, ack held high throughout (does not shorten HOLD)
    wait_cyc(10);
    q.push_back('{11, 1, 8});
    pulse_sw();
    wait_cyc(20);
    chk("sw_busy_low_at_20", int'(busy), 0);

    // Watchdog timeout, load 5, no kicks
    wait_cyc(25);
    wdt_load = 16'd5;
    wdt_en   = 1'b1;
    q.push_back('{32, 2, 8});
    wait_cyc(26);
    chk("wdt_loaded", int'(wdt_cnt), 5);
    wait_cyc(31);
    chk("wdt_at_zero", int'(wdt_cnt), 0);
    wait_cyc(32);
    chk("wdt_busy", int'(busy), 1);
    wdt_en = 1'b0;

    // Kicked every 3 cycles: no request, count bottoms out at 3
    wait_cyc(45);
    wdt_load = 16'd5;
    wdt_en   = 1'b1;
    min_cnt  = 1000;
    saw_req  = 0;
    for (int i = 1; i <= 100; i++) begin
      wait_cyc(45 + i);
      if (int'(wdt_cnt) < min_cnt) min_cnt = int'(wdt_cnt);
      if (rst_req) saw_req = 1;
      wdt_kick = (i % 3 == 2);
    end
    wdt_kick = 1'b0;
    wdt_en   = 1'b0;
    chk("kick_min_cnt", min_cnt, 3);
    chk("kick_no_req", saw_req, 0);

    // Software and timeout in the same cycle (load 0), second sw during HOLD ignored
    wait_cyc(150);
    wdt_load = 16'd0;
    wdt_en   = 1'b1;
    wait_cyc(151);
    q.push_back('{152, 3, 8});
    sw_rst_req = 1'b1;
    wait_cyc(152);
    sw_rst_req = 1'b0;
    wdt_en     = 1'b0;
    wait_cyc(154);
    pulse_sw();
    wait_cyc(158);
    chk("both_cause_sticky", int'(rst_cause), 3);

    // Ack withheld for 20 cycles after HOLD
    wait_cyc(170);
    rst_ack = 1'b0;
    q.push_back('{171, 1, 28});
    pulse_sw();
    wait_cyc(198);
    rst_ack = 1'b1;

    // Asynchronous reset in the middle of HOLD
    wait_cyc(205);
    wdt_load = 16'd50;
    wdt_en   = 1'b1;
    wait_cyc(210);
    q.push_back('{211, 1, 4});
    pulse_sw();
    wait_cyc(214);
    chk("mid_hold_cnt", int'(wdt_cnt), 42);
    chk("mid_hold_req", int'(rst_req), 1);
    #2;
    rst_   = 1'b0;
    wdt_en = 1'b0;
    #1;
    chk("async_rst_req", int'(rst_req), 0);
    chk("async_rst_cause", int'(rst_cause), 0);
    chk("async_rst_cnt", int'(wdt_cnt), 0);
    chk("async_rst_busy", int'(busy), 0);
    wait_cyc(217);
    rst_ = 1'b1;

`ifdef YUTORINA_WDT_WARN_EN
    begin
      int n_warn;
      int warn_cyc;
      int warn_val;
      n_warn   = 0;
      warn_cyc = -1;
      warn_val = -1;
      wait_cyc(220);
      wdt_load = 16'd100;
      wdt_en   = 1'b1;
      for (int i = 221; i <= 270; i++) begin
        wait_cyc(i);
        if (wdt_warn) begin
          n_warn++;
          warn_cyc = cyc;
          warn_val = int'(wdt_cnt);
        end
      end
      wdt_en = 1'b0;
      chk("warn_count", n_warn, 1);
      chk("warn_cycle", warn_cyc, 257);
      chk("warn_cnt_val", warn_val, 64);
    end
`endif

    wait_cyc(280);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
